// File: rtl/cache_refill_pkg.sv
// ---------------------------------------------------------------------------
// cache_refill_pkg
// Shared definitions for the cache line refill engine: line geometry, AXI4
// read-burst encodings, FSM state encoding and a set-index helper.
// The tag array's CACHE_DEPTH must equal CACHE_DEPTH below (2**INDEX_WIDTH).
// ---------------------------------------------------------------------------
package cache_refill_pkg;

    // Line geometry: 8 x 32-bit words = 32-byte line.
    localparam int LINE_WORDS   = 8;
    localparam int INDEX_WIDTH  = 7;
    localparam int OFFSET_WIDTH = 5;
    localparam int WORD_WIDTH   = $clog2(LINE_WORDS);
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int CACHE_DEPTH  = 2 ** INDEX_WIDTH;

    // AXI4 read-address encodings.
    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam logic [7:0] AXI_LEN        = 8'(LINE_WORDS - 1);
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Refill FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Set index of a byte address: addr[11:5].
    function automatic logic [INDEX_WIDTH-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_WIDTH +: INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/cache_refill.sv
// ---------------------------------------------------------------------------
// cache_refill
// Refill engine for a direct-mapped cache. On a tag miss it fetches the
// 32-byte line through one AXI4 INCR read burst, writes every beat into the
// data array, then pulses refresh so the tag array marks the line valid.
// One refill is outstanding at a time.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   miss, axi_addr            miss request and line-aligned miss address
//   refresh                   one-cycle pulse: line complete
//   busy                      refill in progress
//   err                       sticky protocol/response error flag
//   data_we/index/word/wdata  data-array word write port
//   arid..arvalid, arready    AXI read-address channel
//   rdata..rvalid, rready     AXI read-data channel
//   dbg_state                 current FSM state (observation only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. arvalid, once raised, stays high with a stable payload until
// arready is seen. rready is high for the whole data phase, so every cycle
// with rvalid high in that phase is one accepted beat.
// ---------------------------------------------------------------------------
module cache_refill
    import cache_refill_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    // cache side
    input  logic                   miss,
    input  logic [ADDR_WIDTH-1:0]  axi_addr,
    output logic                   refresh,
    output logic                   busy,
    output logic                   err,
    output logic                   data_we,
    output logic [INDEX_WIDTH-1:0] data_index,
    output logic [WORD_WIDTH-1:0]  data_word,
    output logic [DATA_WIDTH-1:0]  data_wdata,
    // AXI read address channel
    output logic [3:0]             arid,
    output logic [ADDR_WIDTH-1:0]  araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    // AXI read data channel
    input  logic [DATA_WIDTH-1:0]  rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    // observation
    output state_e                 dbg_state
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [WORD_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                    ovf_q,   ovf_d;   // all LINE_WORDS beats taken, still no rlast
    logic                    skip_q,  skip_d;  // first IDLE cycle after DONE
    logic                    err_q,   err_d;

    logic beat;
    logic last_word;

    assign beat      = (state_q == ST_R) && rvalid;
    assign last_word = (cnt_q == WORD_WIDTH'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        skip_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // The tag array only shows the hit one cycle after refresh,
                // so a miss still high right after DONE is stale.
                if (miss && !skip_q) begin
                    addr_d  = axi_addr;
                    state_d = ST_AR;
                end
            end

            ST_AR: begin
                if (arready) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_R;
                end
            end

            ST_R: begin
                if (rvalid) begin
                    cnt_d = cnt_q + WORD_WIDTH'(1);
                    if (rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // Beats past the end of the line are an error and are
                    // not written; keep draining until the slave ends the burst.
                    if (ovf_q) begin
                        err_d = 1'b1;
                    end
                    if (last_word && !rlast) begin
                        ovf_d = 1'b1;
                    end
                    if (rlast) begin
                        if (!last_word && !ovf_q) begin
                            err_d = 1'b1;  // short burst: tail of line is stale
                        end
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                skip_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // AR payload is driven from the latched address, so it is stable while
    // arvalid is high regardless of what axi_addr does.
    assign arid       = AXI_ID;
    assign araddr     = addr_q;
    assign arlen      = AXI_LEN;
    assign arsize     = AXI_SIZE_4B;
    assign arburst    = AXI_BURST_INCR;
    assign arvalid    = (state_q == ST_AR);
    assign rready     = (state_q == ST_R);

    assign data_we    = beat && !ovf_q;
    assign data_index = line_index(addr_q);
    assign data_word  = cnt_q;
    assign data_wdata = rdata;

    assign refresh    = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
